dmem_responder: RTL and testbench

//  Data-memory responder: the memory side of the core's load/store path. It accepts one

---
 rtl/dmem_pkg.sv | 16 +
 rtl/dmem_if.sv | 25 ++
 rtl/dmem_sat_counter.sv | 17 +
 rtl/dmem_responder.sv | 117 +++++++++++
 tb/tb_dmem_responder.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [7:0] DMEM_INIT0 = 8'hFF;
   localparam logic [7:0] DMEM_INIT1 = 8'hFE;
   localparam logic [7:0] DMEM_INIT2 = 8'hFD;

   localparam int DMEM_DEPTH = 11;

endpackage

// File: rtl/dmem_if.sv
// Request/response bus between the core (master) and the data-memory responder (slave).
interface dmem_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dmem_sat_counter.sv
// 16-bit event counter that sticks at 16'hFFFF; one increment per cycle, no backpressure.
module dmem_sat_counter (
   input  logic        clk,
   input  logic        rst,
   input  logic        inc,
   output logic [15:0] count
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (inc && (count != 16'hFFFF)) begin
         count <= count + 16'd1;
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// One-at-a-time data-memory responder, response LATENCY+1 cycles after acceptance, held until rsp_ready.
// DMEM_STATS_EN adds saturating load/store/error counters (stat_rd, stat_wr, stat_err).
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int ADDR_W  = 5,
   parameter int DATA_W  = 8,
   parameter int DEPTH   = DMEM_DEPTH,
   parameter int LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst,
   dmem_if.slave       bus
`ifdef DMEM_STATS_EN
   ,
   output logic [15:0] stat_rd,
   output logic [15:0] stat_wr,
   output logic [15:0] stat_err
`endif
);

   localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];
   localparam logic [3:0]      LAT_L   = LATENCY[3:0];

   state_t            state;
   logic [3:0]        cnt;
   logic              lat_we;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;
   logic [DATA_W-1:0] mem [DEPTH];

   logic              in_range;
   logic [IDX_W-1:0]  idx;
   logic              access;

   // Full-width unsigned compare so high addresses never alias onto real locations.
   assign in_range = ({1'b0, lat_addr} < DEPTH_L);
   assign idx      = lat_addr[IDX_W-1:0];
   assign access   = (state == WAIT) && (cnt == 4'd0);

   assign bus.req_ready = (state == IDLE) && !rst;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         cnt           <= '0;
         lat_we        <= 1'b0;
         lat_addr      <= '0;
         lat_wdata     <= '0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_rdata <= '0;
         bus.rsp_err   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         mem[0] <= DATA_W'(DMEM_INIT0);
         mem[1] <= DATA_W'(DMEM_INIT1);
         mem[2] <= DATA_W'(DMEM_INIT2);
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  lat_we    <= bus.req_we;
                  lat_addr  <= bus.req_addr;
                  lat_wdata <= bus.req_wdata;
                  cnt       <= LAT_L;
                  state     <= WAIT;
               end
            end
            WAIT: begin
               if (cnt == 4'd0) begin
                  if (in_range) begin
                     if (lat_we) begin
                        mem[idx] <= lat_wdata;
                     end
                     bus.rsp_rdata <= lat_we ? lat_wdata : mem[idx];
                     bus.rsp_err   <= 1'b0;
                  end else begin
                     bus.rsp_rdata <= '0;
                     bus.rsp_err   <= 1'b1;
                  end
                  bus.rsp_valid <= 1'b1;
                  state         <= RESP;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  bus.rsp_valid <= 1'b0;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef DMEM_STATS_EN
   logic inc_rd;
   logic inc_wr;
   logic inc_err;

   assign inc_rd  = access && in_range && !lat_we;
   assign inc_wr  = access && in_range && lat_we;
   assign inc_err = access && !in_range;

   dmem_sat_counter u_stat_rd  (.clk(clk), .rst(rst), .inc(inc_rd),  .count(stat_rd));
   dmem_sat_counter u_stat_wr  (.clk(clk), .rst(rst), .inc(inc_wr),  .count(stat_wr));
   dmem_sat_counter u_stat_err (.clk(clk), .rst(rst), .inc(inc_err), .count(stat_err));
`else
   logic unused_access;
   assign unused_access = access;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed requests, decoupled response monitor.
module tb_dmem_responder;

`ifdef DMEM_STATS_EN
   localparam int LAT = 0;
`else
   localparam int LAT = 1;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   dmem_if #(.ADDR_W(5), .DATA_W(8)) bus ();

`ifdef DMEM_STATS_EN
   logic [15:0] stat_rd;
   logic [15:0] stat_wr;
   logic [15:0] stat_err;
`endif

   dmem_responder #(
      .ADDR_W (5),
      .DATA_W (8),
      .DEPTH  (11),
      .LATENCY(LAT)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus)
`ifdef DMEM_STATS_EN
      ,
      .stat_rd (stat_rd),
      .stat_wr (stat_wr),
      .stat_err(stat_err)
`endif
   );

   typedef struct packed {
      logic [7:0]  rdata;
      logic        err;
      logic [31:0] acc;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   logic       prev_vld = 1'b0;
   logic [7:0] hold_dat = 8'h00;
   logic       hold_err = 1'b0;

   logic [7:0] sweep_exp [11] = '{8'hFF, 8'hFE, 8'hFD, 8'h00, 8'h00, 8'h00,
                                  8'h00, 8'h5A, 8'h00, 8'h00, 8'h00};

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: latency on the rising rsp_valid, stability while stalled, data on handshake.
   always begin
      @(negedge clk);
      #1;
      if (rst) begin
         prev_vld = 1'b0;
      end else if (bus.rsp_valid) begin
         if (prev_vld) begin
            checks++;
            if (bus.rsp_rdata !== hold_dat || bus.rsp_err !== hold_err) begin
               errors++;
               $display("FAIL hold_stable: rdata=%h err=%b required rdata=%h err=%b",
                        bus.rsp_rdata, bus.rsp_err, hold_dat, hold_err);
            end
            checks++;
            if (bus.req_ready !== 1'b0) begin
               errors++;
               $display("FAIL req_ready_in_resp: got %b required 0", bus.req_ready);
            end
         end else if (sb.size() > 0) begin
            checks++;
            if (cyc - int'(sb[0].acc) != LAT + 1) begin
               errors++;
               $display("FAIL latency: got %0d cycles required %0d",
                        cyc - int'(sb[0].acc), LAT + 1);
            end
         end
         hold_dat = bus.rsp_rdata;
         hold_err = bus.rsp_err;
         if (bus.rsp_ready) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_rsp: rdata=%h err=%b required no response",
                        bus.rsp_rdata, bus.rsp_err);
            end else begin
               e = sb.pop_front();
               if (bus.rsp_rdata !== e.rdata || bus.rsp_err !== e.err) begin
                  errors++;
                  $display("FAIL rsp_data: rdata=%h err=%b required rdata=%h err=%b",
                           bus.rsp_rdata, bus.rsp_err, e.rdata, e.err);
               end
            end
            prev_vld = 1'b0;
         end else begin
            prev_vld = 1'b1;
         end
      end else begin
         prev_vld = 1'b0;
      end
   end

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   task automatic issue(input logic we, input logic [4:0] addr, input logic [7:0] wd,
                        input logic [7:0] erd, input logic eerr);
      int n = 0;
      @(negedge clk);
      while (bus.req_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         checks++;
         errors++;
         $display("FAIL req_ready_timeout: got %b required 1", bus.req_ready);
      end else begin
         bus.req_valid = 1'b1;
         bus.req_we    = we;
         bus.req_addr  = addr;
         bus.req_wdata = wd;
         sb.push_back('{erd, eerr, 32'(cyc + 1)});
         @(negedge clk);
         bus.req_valid = 1'b0;
      end
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (sb.size() > 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL %s_timeout: %0d responses outstanding required 0", name, sb.size());
         sb.delete();
      end
   endtask

   task automatic rq(input logic we, input logic [4:0] addr, input logic [7:0] wd,
                     input logic [7:0] erd, input logic eerr);
      issue(we, addr, wd, erd, eerr);
      wait_done("rsp");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int n;
      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.rsp_ready = 1'b1;
      rst           = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_req_ready", 16'(bus.req_ready), 16'h0);
      chk("rst_rsp_valid", 16'(bus.rsp_valid), 16'h0);
      chk("rst_rsp_rdata", 16'(bus.rsp_rdata), 16'h0);
      chk("rst_rsp_err",   16'(bus.rsp_err),   16'h0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("idle_req_ready", 16'(bus.req_ready), 16'h1);

      // Reset image and first-transaction latency
      rq(1'b0, 5'd1, 8'h00, 8'hFE, 1'b0);

      // Store then load the same location
      rq(1'b1, 5'd7, 8'h5A, 8'h5A, 1'b0);
      rq(1'b0, 5'd7, 8'h00, 8'h5A, 1'b0);

      // Out-of-range addresses, including the first one past the end
      rq(1'b0, 5'd11, 8'h00, 8'h00, 1'b1);
      rq(1'b0, 5'd31, 8'h00, 8'h00, 1'b1);
      rq(1'b1, 5'd20, 8'h99, 8'h00, 1'b1);
      for (int i = 0; i < 11; i++) begin
         rq(1'b0, 5'(i), 8'h00, sweep_exp[i], 1'b0);
      end

      // Backpressure with ignored request pulses
      bus.rsp_ready = 1'b0;
      issue(1'b0, 5'd2, 8'h00, 8'hFD, 1'b0);
      n = 0;
      while (bus.rsp_valid !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("bp_rsp_seen", 16'(bus.rsp_valid), 16'h1);
      repeat (5) begin
         @(negedge clk);
         bus.req_valid = 1'b1;
         bus.req_we    = 1'b1;
         bus.req_addr  = 5'd3;
         bus.req_wdata = 8'hAA;
         #1;
         chk("bp_req_ready", 16'(bus.req_ready), 16'h0);
         chk("bp_rsp_valid", 16'(bus.rsp_valid), 16'h1);
      end
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      wait_done("bp");
      repeat (4) @(negedge clk);
      rq(1'b0, 5'd3, 8'h00, 8'h00, 1'b0);

      // Reset while a store is waiting
      issue(1'b1, 5'd0, 8'h33, 8'h33, 1'b0);
      rst = 1'b1;
      sb.delete();
      #1;
      chk("midrst_rsp_valid", 16'(bus.rsp_valid), 16'h0);
      chk("midrst_req_ready", 16'(bus.req_ready), 16'h0);
      @(negedge clk);
      rst = 1'b0;
      rq(1'b0, 5'd0, 8'h00, 8'hFF, 1'b0);
      rq(1'b0, 5'd7, 8'h00, 8'h00, 1'b0);

`ifdef DMEM_STATS_EN
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("stat_rd_rst",  stat_rd,  16'd0);
      chk("stat_wr_rst",  stat_wr,  16'd0);
      chk("stat_err_rst", stat_err, 16'd0);
      rq(1'b0, 5'd0,  8'h00, 8'hFF, 1'b0);
      rq(1'b0, 5'd1,  8'h00, 8'hFE, 1'b0);
      rq(1'b0, 5'd2,  8'h00, 8'hFD, 1'b0);
      rq(1'b1, 5'd4,  8'h11, 8'h11, 1'b0);
      rq(1'b1, 5'd5,  8'h22, 8'h22, 1'b0);
      rq(1'b0, 5'd15, 8'h00, 8'h00, 1'b1);
      #1;
      chk("stat_rd",  stat_rd,  16'd3);
      chk("stat_wr",  stat_wr,  16'd2);
      chk("stat_err", stat_err, 16'd1);
`endif

      repeat (5) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
